insn_encode: RTL and testbench

- Pipelined RV32I instruction encoder; the inverse of the decode stage.
- Accepts decoded fields (opcode, alu/bcu/lsu op, register indices, full 32-bit immediate) over a valid/ready handshake.
- Range-checks and packs them into a standard 32-bit RV32I word, and emits it with a wrapping word address for writing into instruction memory.
- Used by the boot-loader/program-writer path and as the reference model in decode round-trip tests.

---
 rtl/insn_encode_pkg.sv | 29 ++
 rtl/insn_pack.sv | 100 ++++++++++
 rtl/insn_encode.sv | 103 ++++++++++
 tb/tb_insn_encode.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/insn_encode_pkg.sv
// Shared RV32I encoding constants and the decoded-field payload.
package insn_encode_pkg;

    localparam int unsigned INSN_W = 32;

    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_ALUIMM = 5'b00100;
    localparam logic [4:0] OP_ALU    = 5'b01100;

    localparam logic [INSN_W-1:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic [4:0]        opcode;
        logic [3:0]        alu_op;
        logic [2:0]        bcu_op;
        logic [2:0]        lsu_op;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [INSN_W-1:0] imm;
    } insn_fields_t;

endpackage

// File: rtl/insn_pack.sv
// Combinational RV32I field packer with range checking; illegal input yields a NOP.
module insn_pack
    import insn_encode_pkg::*;
(
    input  insn_fields_t      fields_i,
    output logic [INSN_W-1:0] insn_c_o,
    output logic              err_c_o
);

    logic [INSN_W-1:0] imm;
    logic [2:0]        f3;
    logic              i_rng_ok;
    logic              b_rng_ok;
    logic              j_rng_ok;
    logic [INSN_W-1:0] word;
    logic              bad;

    assign imm = fields_i.imm;
    assign f3  = fields_i.alu_op[2:0];

    // Immediate fits the signed field width when all bits above it copy the sign bit.
    assign i_rng_ok = (&imm[31:11]) | ~(|imm[31:11]);
    assign b_rng_ok = (&imm[31:12]) | ~(|imm[31:12]);
    assign j_rng_ok = (&imm[31:20]) | ~(|imm[31:20]);

    // Format selection and legality check per major opcode.
    always_comb begin
        word      = '0;
        bad       = 1'b0;
        word[1:0] = 2'b11;
        word[6:2] = fields_i.opcode;
        case (fields_i.opcode)
            OP_ALU: begin
                word[11:7]  = fields_i.rd;
                word[14:12] = f3;
                word[19:15] = fields_i.rs1;
                word[24:20] = fields_i.rs2;
                word[30]    = fields_i.alu_op[3];
                bad = fields_i.alu_op[3] && (f3 != 3'b000) && (f3 != 3'b101);
            end
            OP_ALUIMM: begin
                word[11:7]  = fields_i.rd;
                word[14:12] = f3;
                word[19:15] = fields_i.rs1;
                word[31:20] = imm[11:0];
                bad = fields_i.alu_op[3] || !i_rng_ok;
                if (f3 == 3'b001 && imm[11:5] != 7'b0000000) begin
                    bad = 1'b1;
                end
                if (f3 == 3'b101 && imm[11:5] != 7'b0000000 && imm[11:5] != 7'b0100000) begin
                    bad = 1'b1;
                end
            end
            OP_LOAD, OP_JALR: begin
                word[11:7]  = fields_i.rd;
                word[14:12] = (fields_i.opcode == OP_LOAD) ? fields_i.lsu_op : 3'b000;
                word[19:15] = fields_i.rs1;
                word[31:20] = imm[11:0];
                bad = !i_rng_ok;
            end
            OP_STORE: begin
                word[11:7]  = imm[4:0];
                word[14:12] = fields_i.lsu_op;
                word[19:15] = fields_i.rs1;
                word[24:20] = fields_i.rs2;
                word[31:25] = imm[11:5];
                bad = !i_rng_ok;
            end
            OP_BRANCH: begin
                word[7]     = imm[11];
                word[11:8]  = imm[4:1];
                word[14:12] = fields_i.bcu_op;
                word[19:15] = fields_i.rs1;
                word[24:20] = fields_i.rs2;
                word[30:25] = imm[10:5];
                word[31]    = imm[12];
                bad = imm[0] || !b_rng_ok;
            end
            OP_LUI, OP_AUIPC: begin
                word[11:7]  = fields_i.rd;
                word[31:12] = imm[31:12];
                bad = (imm[11:0] != 12'h000);
            end
            OP_JAL: begin
                word[11:7]  = fields_i.rd;
                word[19:12] = imm[19:12];
                word[20]    = imm[11];
                word[30:21] = imm[10:1];
                word[31]    = imm[20];
                bad = imm[0] || !j_rng_ok;
            end
            default: begin
                bad = 1'b1;
            end
        endcase
        insn_c_o = bad ? NOP_INSN : word;
        err_c_o  = bad;
    end

endmodule

// File: rtl/insn_encode.sv
// RV32I encoder: one output register stage, valid/ready handshake, wrapping word address.
module insn_encode
    import insn_encode_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        opcode,
    input  logic [3:0]        alu_op,
    input  logic [2:0]        bcu_op,
    input  logic [2:0]        lsu_op,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [INSN_W-1:0] imm,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_base,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INSN_W-1:0] insn,
    output logic [ADDR_W-1:0] addr,
    output logic              out_err,
    output logic              err_sticky
);

    insn_fields_t      fields;
    logic [INSN_W-1:0] pack_insn;
    logic              pack_err;
    logic              accept;

    logic              valid_q,  valid_d;
    logic [INSN_W-1:0] insn_q,   insn_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic              err_q,    err_d;
    logic              sticky_q, sticky_d;
    logic [ADDR_W-1:0] cnt_q,    cnt_d;

    assign fields = '{opcode: opcode, alu_op: alu_op, bcu_op: bcu_op, lsu_op: lsu_op,
                      rd: rd, rs1: rs1, rs2: rs2, imm: imm};

    insn_pack u_pack (
        .fields_i (fields),
        .insn_c_o (pack_insn),
        .err_c_o  (pack_err)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Output stage load/drain and address counter next state.
    always_comb begin
        valid_d  = valid_q;
        insn_d   = insn_q;
        addr_d   = addr_q;
        err_d    = err_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (accept) begin
            valid_d  = 1'b1;
            insn_d   = pack_insn;
            addr_d   = cnt_q;
            err_d    = pack_err;
            sticky_d = sticky_q | pack_err;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        // A coincident load wins: the counter lands on addr_base, not addr_base+1.
        if (addr_load) begin
            cnt_d = addr_base;
        end else if (accept) begin
            cnt_d = cnt_q + ADDR_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            insn_q   <= '0;
            addr_q   <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            insn_q   <= insn_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign insn       = insn_q;
    assign addr       = addr_q;
    assign out_err    = err_q;
    assign err_sticky = sticky_q;

endmodule

// File: tb/tb_insn_encode.sv
// Bench for insn_encode (ADDR_W=4): directed cases plus randomized traffic vs a reference model.
module tb_insn_encode;

    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    opcode = '0;
    logic [3:0]    alu_op = '0;
    logic [2:0]    bcu_op = '0;
    logic [2:0]    lsu_op = '0;
    logic [4:0]    rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0]   imm = '0;
    logic          addr_load = 1'b0;
    logic [AW-1:0] addr_base = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   insn;
    logic [AW-1:0] addr;
    logic          out_err;
    logic          err_sticky;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state of what the output port should show.
    bit            m_valid = 0;
    logic [31:0]   m_insn = '0;
    logic [AW-1:0] m_addr = '0;
    bit            m_err = 0;
    bit            m_sticky = 0;
    logic [AW-1:0] m_cnt = '0;

    logic [31:0]   saved_insn;
    logic [AW-1:0] saved_addr;

    always #5 clk = ~clk;

    insn_encode #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .alu_op(alu_op), .bcu_op(bcu_op), .lsu_op(lsu_op),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .addr_load(addr_load), .addr_base(addr_base),
        .out_valid(out_valid), .out_ready(out_ready), .insn(insn), .addr(addr),
        .out_err(out_err), .err_sticky(err_sticky)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Encoding from the ISA rules, with legality decided on signed immediate ranges.
    function automatic void ref_encode(input logic [4:0] op, input logic [3:0] aop,
                                       input logic [2:0] bop, input logic [2:0] lop,
                                       input logic [4:0] d, input logic [4:0] s1,
                                       input logic [4:0] s2, input logic [31:0] im,
                                       output logic [31:0] w, output bit e);
        int signed v;
        logic [2:0] f3;
        v  = im;
        f3 = aop[2:0];
        e  = 0;
        w  = '0;
        case (op)
            5'b01100: begin
                e = aop[3] && !(f3 == 0 || f3 == 5);
                w = {1'b0, aop[3], 5'b0, s2, s1, f3, d, op, 2'b11};
            end
            5'b00100: begin
                e = aop[3] || v < -2048 || v > 2047;
                if (f3 == 1 && im[11:5] != 0) e = 1;
                if (f3 == 5 && !(im[11:5] == 0 || im[11:5] == 7'h20)) e = 1;
                w = {im[11:0], s1, f3, d, op, 2'b11};
            end
            5'b00000: begin
                e = v < -2048 || v > 2047;
                w = {im[11:0], s1, lop, d, op, 2'b11};
            end
            5'b11001: begin
                e = v < -2048 || v > 2047;
                w = {im[11:0], s1, 3'b000, d, op, 2'b11};
            end
            5'b01000: begin
                e = v < -2048 || v > 2047;
                w = {im[11:5], s2, s1, lop, im[4:0], op, 2'b11};
            end
            5'b11000: begin
                e = (v % 2 != 0) || v < -4096 || v > 4095;
                w = {im[12], im[10:5], s2, s1, bop, im[4:1], im[11], op, 2'b11};
            end
            5'b01101, 5'b00101: begin
                e = (v % 4096) != 0;
                w = {im[31:12], d, op, 2'b11};
            end
            5'b11011: begin
                e = (v % 2 != 0) || v < -(1 << 20) || v > (1 << 20) - 1;
                w = {im[20], im[10:1], im[11], im[19:12], d, op, 2'b11};
            end
            default: e = 1;
        endcase
        if (e) w = 32'h0000_0013;
    endfunction

    task automatic set_f(input logic [4:0] op, input logic [3:0] aop, input logic [2:0] bop,
                         input logic [2:0] lop, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [31:0] im);
        opcode = op; alu_op = aop; bcu_op = bop; lsu_op = lop;
        rd = d; rs1 = s1; rs2 = s2; imm = im;
    endtask

    // One clock: check ready, advance the model on the edge, then check outputs.
    task automatic tick();
        bit          acc;
        logic [31:0] e_w;
        bit          e_e;
        #1;
        if (!rst) chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
        acc = in_valid && (!m_valid || out_ready);
        ref_encode(opcode, alu_op, bcu_op, lsu_op, rd, rs1, rs2, imm, e_w, e_e);
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_insn = '0; m_addr = '0; m_err = 0; m_sticky = 0; m_cnt = '0;
        end else begin
            if (acc) begin
                m_valid = 1; m_insn = e_w; m_addr = m_cnt; m_err = e_e;
                m_sticky = m_sticky | e_e;
            end else if (out_ready) begin
                m_valid = 0;
            end
            if (addr_load) m_cnt = addr_base;
            else if (acc) m_cnt = m_cnt + 1'b1;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
        if (m_valid) begin
            chk("insn", insn, m_insn);
            chk("addr", 32'(addr), 32'(m_addr));
            chk("out_err", 32'(out_err), 32'(m_err));
        end
    endtask

    initial begin
        // Reset state.
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_insn", insn, 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        chk("rst_sticky", 32'(err_sticky), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        // Known encodings.
        in_valid = 1'b1;
        set_f(5'b00100, 4'b0000, 3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        chk("addi", insn, 32'h0050_0093);
        chk("addi_addr", 32'(addr), 32'd0);
        chk("addi_vld", 32'(out_valid), 32'd1);
        set_f(5'b11011, 4'b0, 3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        tick();
        chk("jal", insn, 32'h0010_00EF);
        chk("jal_addr", 32'(addr), 32'd1);
        set_f(5'b01100, 4'b1000, 3'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        chk("sub", insn, 32'h4020_81B3);
        set_f(5'b11000, 4'b0, 3'b000, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        tick();
        chk("beq", insn, 32'hFE20_8EE3);
        chk("sticky_clean", 32'(err_sticky), 32'd0);

        // Unencodable words still take an address.
        set_f(5'b01101, 4'b0, 3'd0, 3'd0, 5'd4, 5'd0, 5'd0, 32'h0000_1234);
        tick();
        chk("lui_bad", insn, 32'h0000_0013);
        chk("lui_err", 32'(out_err), 32'd1);
        chk("lui_addr", 32'(addr), 32'd4);
        set_f(5'b11011, 4'b0, 3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd3);
        tick();
        chk("jal_bad", insn, 32'h0000_0013);
        chk("jal_bad_addr", 32'(addr), 32'd5);
        chk("sticky_set", 32'(err_sticky), 32'd1);
        in_valid = 1'b0;
        tick();

        // Backpressure: held word stays put, nothing accepted.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_f(5'b00100, 4'b0000, 3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        saved_insn = insn;
        saved_addr = addr;
        set_f(5'b01100, 4'b1000, 3'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_ready", 32'(in_ready), 32'd0);
            chk("hold_insn", insn, saved_insn);
            chk("hold_addr", 32'(addr), 32'(saved_addr));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_f(5'b00100, 4'b0000, 3'd0, 3'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i));
            tick();
            chk("b2b_vld", 32'(out_valid), 32'd1);
            chk("b2b_addr", 32'(addr), 32'(AW'(saved_addr + 1 + i)));
        end
        in_valid = 1'b0;
        tick();

        // Address wrap and coincident load.
        addr_load = 1'b1;
        addr_base = 4'd15;
        tick();
        addr_load = 1'b0;
        in_valid  = 1'b1;
        tick();
        chk("wrap_15", 32'(addr), 32'd15);
        tick();
        chk("wrap_0", 32'(addr), 32'd0);
        tick();
        chk("pre_load", 32'(addr), 32'd1);
        addr_load = 1'b1;
        addr_base = 4'd7;
        tick();
        chk("load_same", 32'(addr), 32'd2);
        addr_load = 1'b0;
        tick();
        chk("load_next", 32'(addr), 32'd7);
        in_valid = 1'b0;
        tick();

        // Reset while a word is held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_f(5'b01101, 4'b0, 3'd0, 3'd0, 5'd4, 5'd0, 5'd0, 32'h0000_1234);
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_valid", 32'(out_valid), 32'd0);
        chk("rst2_sticky", 32'(err_sticky), 32'd0);
        #1;
        chk("rst2_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_f(5'b00100, 4'b0000, 3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        chk("rst2_addr", 32'(addr), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            logic [4:0] ops[9];
            int         mode;
            ops = '{5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000,
                    5'b00000, 5'b01000, 5'b00100, 5'b01100};
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            addr_load = ($urandom_range(0, 19) == 0);
            addr_base = AW'($urandom);
            rst       = ($urandom_range(0, 99) == 0);
            opcode    = ($urandom_range(0, 7) == 0) ? 5'($urandom) : ops[$urandom_range(0, 8)];
            alu_op    = 4'($urandom);
            bcu_op    = 3'($urandom);
            lsu_op    = 3'($urandom);
            rd        = 5'($urandom);
            rs1       = 5'($urandom);
            rs2       = 5'($urandom);
            mode      = $urandom_range(0, 4);
            case (mode)
                0: imm = 32'($signed($urandom_range(0, 8191)) - 4096);
                1: imm = {20'($urandom) & 20'hFF000 | {20{$urandom_range(0, 1) == 1}} & 20'hFFF00, 12'h000};
                2: imm = {20'h0, ($urandom_range(0, 1) == 1) ? 7'h20 : 7'($urandom_range(0, 2)), 5'($urandom)};
                3: imm = 32'($signed($urandom_range(0, 2097151)) - 1048576) & ~32'($urandom_range(0, 1));
                default: imm = $urandom;
            endcase
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
